// File: rtl/intc_pkg.sv
// Shared types and constants for the vectored interrupt controller.
package intc_pkg;

  localparam int unsigned NUM_IRQ_MIN = 2;
  localparam int unsigned NUM_IRQ_MAX = 32;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} state_e;

  function automatic int unsigned intc_vec_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-first priority encoder; purely combinational.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned VEC_W   = intc_vec_w(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [VEC_W-1:0]   index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downwards so the lowest set index is written last and wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = VEC_W'(i);
    end
  end

endmodule

// File: rtl/intc_vectored.sv
// Vectored interrupt controller: sync, pending, mask, fixed-priority grant, ack/return handshake.
// Define INTC_EDGE_DETECT_EN for edge-triggered pending; default build is level-sensitive.
module intc_vectored
  import intc_pkg::*;
#(
  parameter int unsigned  NUM_IRQ = 8,
  localparam int unsigned VEC_W   = intc_vec_w(NUM_IRQ)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_IRQ-1:0] HardwareInterrupt,
  input  logic               InterruptIn,
  input  logic               MaskWrite,
  input  logic [NUM_IRQ-1:0] MaskData,
  input  logic               IntAck,
  input  logic               IntRet,
  output logic               InterruptTrue,
  output logic [VEC_W-1:0]   IntVector,
  output logic [NUM_IRQ-1:0] Pending,
  output logic [NUM_IRQ-1:0] Mask,
  output logic               InService
);

  if ((NUM_IRQ < NUM_IRQ_MIN) || (NUM_IRQ > NUM_IRQ_MAX)) begin : g_bad_num_irq
    $error("intc_vectored: NUM_IRQ out of legal range");
  end

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, pending_q, pending_d, mask_q, eligible;
  logic [VEC_W-1:0]   vec_q, grant_idx;
  logic               grant_valid, int_true_q, in_service_q;
  state_e             state_q;

`ifdef INTC_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] prev_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) prev_q <= '0;
    else        prev_q <= sync2_q;
  end
`endif

  always_comb begin
`ifdef INTC_EDGE_DETECT_EN
    pending_d = pending_q;
    if ((state_q == ST_REQ) && IntAck) pending_d[vec_q] = 1'b0;
    // A new edge on the bit being acknowledged keeps it pending.
    pending_d = pending_d | (sync2_q & ~prev_q);
`else
    pending_d = sync2_q;
`endif
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      sync1_q   <= HardwareInterrupt;
      sync2_q   <= sync1_q;
      pending_q <= pending_d;
      if (MaskWrite) mask_q <= MaskData;
    end
  end

  assign eligible = pending_q & ~mask_q;

  intc_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .req   (eligible),
    .valid (grant_valid),
    .index (grant_idx)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      int_true_q   <= 1'b0;
      in_service_q <= 1'b0;
      vec_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (InterruptIn && grant_valid) begin
            state_q    <= ST_REQ;
            int_true_q <= 1'b1;
            vec_q      <= grant_idx;
          end
        end
        ST_REQ: begin
          if (IntAck) begin
            state_q      <= ST_SERVICE;
            int_true_q   <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!InterruptIn) begin
            state_q    <= ST_IDLE;
            int_true_q <= 1'b0;
          end
        end
        ST_SERVICE: begin
          if (IntRet) begin
            state_q      <= ST_IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          int_true_q   <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign InterruptTrue = int_true_q;
  assign InService     = in_service_q;
  assign IntVector     = vec_q;
  assign Pending       = pending_q;
  assign Mask          = mask_q;

endmodule

// File: tb/tb_intc_vectored.sv
// Self-checking bench for intc_vectored: vector table, directed corner sequences, random vs model.
module tb_intc_vectored;

  localparam int unsigned NUM = 8;
  localparam int unsigned VW  = 3;

  logic           CLK = 1'b0;
  logic           RST_N;
  logic [NUM-1:0] HardwareInterrupt;
  logic           InterruptIn;
  logic           MaskWrite;
  logic [NUM-1:0] MaskData;
  logic           IntAck;
  logic           IntRet;
  logic           InterruptTrue;
  logic [VW-1:0]  IntVector;
  logic [NUM-1:0] Pending;
  logic [NUM-1:0] Mask;
  logic           InService;

  int total = 0;
  int bad   = 0;

  intc_vectored #(
    .NUM_IRQ (NUM)
  ) dut (
    .CLK               (CLK),
    .RST_N             (RST_N),
    .HardwareInterrupt (HardwareInterrupt),
    .InterruptIn       (InterruptIn),
    .MaskWrite         (MaskWrite),
    .MaskData          (MaskData),
    .IntAck            (IntAck),
    .IntRet            (IntRet),
    .InterruptTrue     (InterruptTrue),
    .IntVector         (IntVector),
    .Pending           (Pending),
    .Mask              (Mask),
    .InService         (InService)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [NUM-1:0] hw;
    logic [NUM-1:0] mask;
    logic [NUM-1:0] exp_pend;
    logic           exp_req;
    logic [VW-1:0]  exp_vec;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    HardwareInterrupt = '0;
    InterruptIn       = 1'b1;
    MaskWrite         = 1'b0;
    MaskData          = '0;
    IntAck            = 1'b0;
    IntRet            = 1'b0;
    RST_N             = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
  endtask

  // Reference model: raw sample history replaces the synchroniser.
  logic [NUM-1:0] h1, h2, h3, m_pend, m_mask;
  logic [VW-1:0]  m_vec;
  int             m_mode;  // 0 idle, 1 requesting, 2 in service

  task automatic model_clear();
    h1 = '0; h2 = '0; h3 = '0; m_pend = '0; m_mask = '0; m_vec = '0; m_mode = 0;
  endtask

  task automatic model_step();
    logic [NUM-1:0] elig;
    int             win;
    int             nmode;
    logic           clr;
    elig  = m_pend & ~m_mask;
    win   = -1;
    nmode = m_mode;
    clr   = 1'b0;
    for (int i = NUM - 1; i >= 0; i--) if (elig[i]) win = i;
    if (m_mode == 0) begin
      if (InterruptIn && win >= 0) begin
        nmode = 1;
        m_vec = VW'(win);
      end
    end else if (m_mode == 1) begin
      if (IntAck) begin
        nmode = 2;
        clr   = 1'b1;
      end else if (!InterruptIn) begin
        nmode = 0;
      end
    end else if (IntRet) begin
      nmode = 0;
    end
`ifdef INTC_EDGE_DETECT_EN
    if (clr) m_pend[m_vec] = 1'b0;
    m_pend = m_pend | (h2 & ~h3);
`else
    m_pend = h2;
`endif
    if (MaskWrite) m_mask = MaskData;
    m_mode = nmode;
    h3 = h2;
    h2 = h1;
    h1 = HardwareInterrupt;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{hw: 8'h80, mask: 8'h00, exp_pend: 8'h80, exp_req: 1'b1, exp_vec: 3'd7};
    tbl[1] = '{hw: 8'h24, mask: 8'h00, exp_pend: 8'h24, exp_req: 1'b1, exp_vec: 3'd2};
    tbl[2] = '{hw: 8'h04, mask: 8'h04, exp_pend: 8'h04, exp_req: 1'b0, exp_vec: 3'd0};
    tbl[3] = '{hw: 8'hff, mask: 8'h00, exp_pend: 8'hff, exp_req: 1'b1, exp_vec: 3'd0};
    tbl[4] = '{hw: 8'hf0, mask: 8'h30, exp_pend: 8'hf0, exp_req: 1'b1, exp_vec: 3'd6};
    tbl[5] = '{hw: 8'h01, mask: 8'hfe, exp_pend: 8'h01, exp_req: 1'b1, exp_vec: 3'd0};
    tbl[6] = '{hw: 8'h81, mask: 8'h01, exp_pend: 8'h81, exp_req: 1'b1, exp_vec: 3'd7};
    tbl[7] = '{hw: 8'h00, mask: 8'h00, exp_pend: 8'h00, exp_req: 1'b0, exp_vec: 3'd0};

    do_reset();
    chk("reset outputs", {InterruptTrue, InService, IntVector, Pending, Mask}, 32'd0);

    // One-cycle pulse at edge N: Pending at N+2, request at N+3.
    for (int t = 0; t < 8; t++) begin
      do_reset();
      if (tbl[t].mask != '0) begin
        MaskWrite = 1'b1;
        MaskData  = tbl[t].mask;
        cyc();
        MaskWrite = 1'b0;
      end
      HardwareInterrupt = tbl[t].hw;
      cyc();
      HardwareInterrupt = '0;
      cyc();
      cyc();
      chk($sformatf("tbl%0d pending", t), Pending, tbl[t].exp_pend);
      cyc();
      chk($sformatf("tbl%0d req", t), InterruptTrue, tbl[t].exp_req);
      chk($sformatf("tbl%0d vec", t), IntVector, tbl[t].exp_vec);
    end

    // Two lines at once: serve 2, then 5 (edge mode keeps 5 pending).
    do_reset();
    HardwareInterrupt = 8'h24;
    cyc();
    HardwareInterrupt = '0;
    cyc(); cyc(); cyc();
    chk("pair first vec", {InterruptTrue, IntVector}, {1'b1, 3'd2});
    IntAck = 1'b1;
    cyc();
    IntAck = 1'b0;
    chk("pair ack state", {InterruptTrue, InService}, 2'b01);
`ifdef INTC_EDGE_DETECT_EN
    chk("pair ack pending", Pending, 8'h20);
`else
    chk("pair ack pending", Pending, 8'h00);
`endif
    IntRet = 1'b1;
    cyc();
    IntRet = 1'b0;
    chk("pair ret state", {InterruptTrue, InService}, 2'b00);
    cyc();
`ifdef INTC_EDGE_DETECT_EN
    chk("pair second vec", {InterruptTrue, IntVector}, {1'b1, 3'd5});
`else
    chk("pair second req", InterruptTrue, 1'b0);
`endif

    // Line 1 held high through ack and return.
    do_reset();
    HardwareInterrupt = 8'h02;
    cyc(); cyc(); cyc(); cyc();
    chk("hold vec", {InterruptTrue, IntVector}, {1'b1, 3'd1});
    IntAck = 1'b1;
    cyc();
    IntAck = 1'b0;
    IntRet = 1'b1;
    cyc();
    IntRet = 1'b0;
    chk("hold ret", {InterruptTrue, InService}, 2'b00);
    cyc();
`ifdef INTC_EDGE_DETECT_EN
    chk("hold rerequest", InterruptTrue, 1'b0);
`else
    chk("hold rerequest", {InterruptTrue, IntVector}, {1'b1, 3'd1});
`endif

    // Masked line pends without requesting; unmask requests one cycle later.
    do_reset();
    MaskWrite = 1'b1;
    MaskData  = 8'h04;
    cyc();
    MaskWrite = 1'b0;
    chk("mask loaded", Mask, 8'h04);
    HardwareInterrupt = 8'h04;
    cyc(); cyc(); cyc();
    chk("masked pending", Pending, 8'h04);
    cyc(); cyc();
    chk("masked no req", InterruptTrue, 1'b0);
    MaskWrite = 1'b1;
    MaskData  = 8'h00;
    cyc();
    MaskWrite = 1'b0;
    chk("unmask same edge", InterruptTrue, 1'b0);
    cyc();
    chk("unmask req", {InterruptTrue, IntVector}, {1'b1, 3'd2});
    HardwareInterrupt = '0;

    // Drop InterruptIn in REQ, reassert, then reset during service.
    do_reset();
    HardwareInterrupt = 8'h08;
    cyc(); cyc(); cyc(); cyc();
    chk("drop pre", {InterruptTrue, IntVector}, {1'b1, 3'd3});
    InterruptIn = 1'b0;
    cyc();
    chk("drop idle", {InterruptTrue, IntVector, Pending}, {1'b0, 3'd3, 8'h08});
    InterruptIn = 1'b1;
    cyc();
    chk("reassert", {InterruptTrue, IntVector}, {1'b1, 3'd3});
    IntAck    = 1'b1;
    MaskWrite = 1'b1;
    MaskData  = 8'hff;
    cyc();
    IntAck    = 1'b0;
    MaskWrite = 1'b0;
    chk("svc with mask", {InService, Mask}, {1'b1, 8'hff});
    HardwareInterrupt = '0;
    #2;
    RST_N = 1'b0;
    #1;
    chk("async reset", {InterruptTrue, InService, IntVector, Pending, Mask}, 32'd0);
    @(negedge CLK);
    RST_N  = 1'b1;
    IntRet = 1'b1;
    cyc();
    IntRet = 1'b0;
    chk("ret after reset", {InterruptTrue, InService}, 2'b00);

    // Random traffic against the reference model.
    do_reset();
    model_clear();
    for (int c = 0; c < 600; c++) begin
      HardwareInterrupt = NUM'($urandom & $urandom & $urandom);
      InterruptIn       = ($urandom % 8) != 0;
      MaskWrite         = ($urandom % 16) == 0;
      MaskData          = NUM'($urandom & $urandom);
      IntAck            = ($urandom % 3) == 0;
      IntRet            = ($urandom % 3) == 0;
      model_step();
      cyc();
      chk($sformatf("rand c%0d {req,svc,vec,pend,mask}", c),
          {InterruptTrue, InService, IntVector, Pending, Mask},
          {m_mode == 1, m_mode == 2, m_vec, m_pend, m_mask});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/intc_vectored.md
# intc_vectored

Parametrised, vectored interrupt controller between the external hardware interrupt lines and the multicycle control state machine. It synchronises NUM_IRQ request lines, latches them into a pending register, and masks them. It arbitrates by fixed priority, where the lowest index wins. It runs a request/acknowledge/return handshake with the control FSM, which asserts EPCWrite in its trap-entry state. It generalises the existing fixed 8-bit HardwareInterrupt/Flipped path with width, masking, vector output and in-service tracking.

## Interface
- NUM_IRQ, 8, number of interrupt lines; legal range 2..32
- VEC_W, $clog2(NUM_IRQ), vector width; derived, never overridden
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- HardwareInterrupt  in  NUM_IRQ  raw asynchronous request lines
- InterruptIn  in  1  global interrupt enable from control
- MaskWrite  in  1  load Mask from MaskData this cycle
- MaskData  in  NUM_IRQ  new mask; 1 = line masked
- IntAck  in  1  control FSM has entered trap state (same cycle as EPCWrite)
- IntRet  in  1  return-from-interrupt executed
- InterruptTrue  out  1  request to control FSM
- IntVector  out  VEC_W  index of granted line; frozen while InterruptTrue or InService
- Pending  out  NUM_IRQ  pending register (successor of Flipped)
- Mask  out  NUM_IRQ  current mask register
- InService  out  1  handler running

## Operation
- Reset values: all outputs 0; Mask = 0 (all enabled); synchroniser, previous-sample and pending registers 0; state IDLE.
- Each line passes through a 2-flop synchroniser, sync1 then sync2. The previous-sample register holds the last sync2 value.
- Pending bit i is set when edge_i = sync2_i & ~prev_i. It is cleared on IntAck when IntVector == i. If set and clear land on the same bit in the same cycle, set wins.
- Masked lines still set Pending. The mask only excludes them from arbitration.
- A line already high when reset releases counts as a rising edge.
- Eligible = Pending & ~Mask. The winner is the lowest set index.
- The FSM has three states:
  - IDLE: if InterruptIn and eligible != 0, capture the winner into IntVector and go to REQ.
  - REQ: InterruptTrue = 1.
    - If IntAck, clear the pending bit and go to SERVICE.
    - Else if !InterruptIn, go to IDLE; the pending bit is retained and IntVector holds its value.
    - If IntAck and !InterruptIn arrive together, IntAck wins.
    - A higher-priority line arriving in REQ does not re-arbitrate.
  - SERVICE: InService = 1, InterruptTrue = 0. On IntRet go to IDLE. No nesting.
- IntAck outside REQ and IntRet outside SERVICE are ignored.
- MaskWrite takes effect at the next edge. A mask change in REQ or SERVICE does not cancel the current grant.
- Asserting RST_N low mid-operation (REQ or SERVICE) immediately returns all registers to their reset values and drops any in-flight grant.

## Timing
- Let N be the edge where HardwareInterrupt is first sampled high into sync1.
  - N+1: sync2 goes high.
  - N+2: Pending bit set.
  - N+3: state REQ, InterruptTrue = 1.
  - Latency from sample to request is 3 cycles.
- IntAck sampled high at edge M: at M, InterruptTrue goes low, InService goes high, and the pending bit clears.
- IntRet sampled at edge R: InService goes low at R. The earliest next InterruptTrue is R+1, because IDLE re-arbitrates for one cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- INTC_EDGE_DETECT_EN defined: edge-triggered pending, as described above.
- INTC_EDGE_DETECT_EN undefined: level-sensitive mode.
  - Pending <= sync2 each cycle; IntAck clears nothing.
  - The previous-sample register is removed.
  - Latency is the same: Pending at N+2, REQ at N+3.
  - If the line drops while the FSM is in REQ, the request is still committed until IntAck or !InterruptIn.

## Structure
- intc_pkg holds:
  - the state enum (ST_IDLE, ST_REQ, ST_SERVICE)
  - the NUM_IRQ legal-range constants
  - a vector-width function used for VEC_W
- Sub-module intc_prio_enc: purely combinational lowest-index-first priority encoder. It takes NUM_IRQ and outputs valid and index. It is instantiated once.

## Test plan
- Edge mode, NUM_IRQ=8, InterruptIn=1, HardwareInterrupt=8'h80 sampled at edge N -> Pending=8'h80 at N+2; InterruptTrue=1, IntVector=7 at N+3; IntAck -> Pending=0, InService=1.
- HardwareInterrupt=8'h24 in one cycle -> IntVector=2; after IntAck and IntRet, IntVector=5 serviced next with InterruptTrue one cycle after IntRet.
- Mask=8'h04 via MaskWrite, HardwareInterrupt=8'h04 -> Pending=8'h04, InterruptTrue stays 0. Mask cleared -> request 1 cycle later.
- In REQ with IntVector=3, drop InterruptIn -> state IDLE, Pending bit 3 held. Reassert -> REQ again with IntVector=3.
- RST_N low during SERVICE -> InService, Pending, Mask and IntVector all 0 immediately. IntRet after reset is ignored.
- Level mode (macro undefined): hold line 1 high through IntAck and IntRet -> re-request of vector 1 one cycle after IntRet.
